// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter.
//   - Default SRAM geometry (byte address width, data width).
//   - Read-return selector encoding (which port owns the data coming back).
//   - Grant vector bit positions and the "read" byte-enable value.
package sram_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  // A zero byte-enable means the access is a read.
  localparam logic [3:0] WEN_READ = 4'b0000;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_DM = 1;
  localparam int GNT_LD = 2;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IF   = 2'd1,
    SEL_DM   = 2'd2,
    SEL_LD   = 2'd3
  } rsel_e;

endpackage

// File: rtl/sram_port_arbiter_arb_priority_sel.sv
// Combinational priority selector with starvation override.
//   en       : grants allowed (low while the arbiter is in reset)
//   if_req   : instruction fetch request
//   dm_req   : data access request
//   ld_req   : loader/debug request (always highest priority)
//   starved  : IF has been passed over long enough to jump ahead of DM
//   gnt_oh   : one-hot grant {LD, DM, IF}, all zero when nothing is granted
module arb_priority_sel
  import sram_port_arbiter_pkg::*;
(
  input  logic       en,
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       ld_req,
  input  logic       starved,
  output logic [2:0] gnt_oh
);

  // LD always wins; between DM and IF, DM wins unless IF is starved.
  always_comb begin
    gnt_oh = 3'b000;
    if (en) begin
      if (ld_req) begin
        gnt_oh[GNT_LD] = 1'b1;
      end else if (if_req && (starved || !dm_req)) begin
        gnt_oh[GNT_IF] = 1'b1;
      end else if (dm_req) begin
        gnt_oh[GNT_DM] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Three-way arbiter sharing one single-port SRAM between instruction fetch
// (IF, read only), data access (DM) and a loader/debug port (LD).
// Ports:
//   clk, rst (async, active low)
//   if_*  : IF request/address in; grant, read-valid, read-data out
//   dm_*  : DM request/byte-enables/address/write-data in; grant/rvalid/rdata out
//   ld_*  : LD request/byte-enables/address/write-data in; grant/rvalid/rdata out
//   sram_*: address, byte enables and write data to the SRAM; read data back
//           (SRAM read data arrives the cycle after the address)
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              dm_req,
  input  logic [3:0]        dm_w_en,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,

  input  logic              ld_req,
  input  logic [3:0]        ld_w_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,

  output logic [3:0]        sram_w_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_write_data,
  input  logic [DATA_W-1:0] sram_read_data
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  rsel_e      rsel_q, rsel_d;
  logic [2:0] gnt_oh;

  arb_priority_sel u_sel (
    .en      (rst),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .ld_req  (ld_req),
    .starved (starve_cnt_q == MAX_WAIT_C),
    .gnt_oh  (gnt_oh)
  );

  assign if_gnt = gnt_oh[GNT_IF];
  assign dm_gnt = gnt_oh[GNT_DM];
  assign ld_gnt = gnt_oh[GNT_LD];

  // LD traffic freezes the count so an LD burst neither helps nor hurts IF.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (ld_gnt) begin
      starve_cnt_d = starve_cnt_q;
    end else if (if_gnt || !if_req) begin
      starve_cnt_d = 4'd0;
    end else if (dm_gnt && starve_cnt_q != MAX_WAIT_C) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // With no grant, present a harmless read at the IF address.
  always_comb begin
    sram_w_en       = WEN_READ;
    sram_address    = if_addr;
    sram_write_data = '0;
    rsel_d          = SEL_NONE;
    if (ld_gnt) begin
      sram_w_en       = ld_w_en;
      sram_address    = ld_addr;
      sram_write_data = ld_wdata;
      if (ld_w_en == WEN_READ) rsel_d = SEL_LD;
    end else if (dm_gnt) begin
      sram_w_en       = dm_w_en;
      sram_address    = dm_addr;
      sram_write_data = dm_wdata;
      if (dm_w_en == WEN_READ) rsel_d = SEL_DM;
    end else if (if_gnt) begin
      rsel_d = SEL_IF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= 4'd0;
      rsel_q       <= SEL_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsel_q       <= rsel_d;
    end
  end

  assign if_rvalid = (rsel_q == SEL_IF);
  assign dm_rvalid = (rsel_q == SEL_DM);
  assign ld_rvalid = (rsel_q == SEL_LD);

  assign if_rdata = sram_read_data;
  assign dm_rdata = sram_read_data;
  assign ld_rdata = sram_read_data;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural byte-write
// SRAM model (one-cycle read latency) attached to the SRAM side.
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic [3:0]  dm_w_en;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        ld_req;
  logic [3:0]  ld_w_en;
  logic [15:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt, ld_rvalid;
  logic [31:0] ld_rdata;
  logic [3:0]  sram_w_en;
  logic [15:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;

  int checks;
  int failures;

  sram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_w_en(dm_w_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .ld_req(ld_req), .ld_w_en(ld_w_en), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .sram_w_en(sram_w_en), .sram_address(sram_address),
    .sram_write_data(sram_write_data), .sram_read_data(sram_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: word-addressed by byte address bits [15:2].
  logic [31:0] mem [0:16383];
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    sram_read_data = 32'h0;
  end
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (sram_w_en[b]) mem[sram_address[15:2]][8*b +: 8] <= sram_write_data[8*b +: 8];
    sram_read_data <= mem[sram_address[15:2]];
  end

  typedef struct {
    string       name;
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic [3:0]  dw;
    logic [15:0] da;
    logic [31:0] dd;
    logic        lr;
    logic [3:0]  lw;
    logic [15:0] la;
    logic [31:0] ldd;
    logic [2:0]  exp_gnt;   // {ld, dm, if}
    logic [3:0]  exp_wen;
    logic [15:0] exp_addr;
    logic [2:0]  exp_rv;    // {ld, dm, if}, next cycle
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm,
      logic ir, logic [15:0] ia,
      logic dr, logic [3:0] dw, logic [15:0] da, logic [31:0] dd,
      logic lr, logic [3:0] lw, logic [15:0] la, logic [31:0] ldd,
      logic [2:0] eg, logic [3:0] ew, logic [15:0] ea,
      logic [2:0] erv, logic [31:0] erd);
    vec_t v;
    v.name = nm; v.ir = ir; v.ia = ia;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.lr = lr; v.lw = lw; v.la = la; v.ldd = ldd;
    v.exp_gnt = eg; v.exp_wen = ew; v.exp_addr = ea;
    v.exp_rv = erv; v.exp_rdata = erd;
    return v;
  endfunction

  task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    if_req = v.ir; if_addr = v.ia;
    dm_req = v.dr; dm_w_en = v.dw; dm_addr = v.da; dm_wdata = v.dd;
    ld_req = v.lr; ld_w_en = v.lw; ld_addr = v.la; ld_wdata = v.ldd;
  endtask

  task automatic drive_dm_if(input logic ir, input logic dr, input logic lr);
    if_req = ir; if_addr = 16'h0010;
    dm_req = dr; dm_w_en = 4'h0; dm_addr = 16'h9000; dm_wdata = 32'h0;
    ld_req = lr; ld_w_en = 4'hF; ld_addr = 16'h0030; ld_wdata = 32'h5A5A5A5A;
  endtask

  function automatic logic [2:0] gnts();
    return {ld_gnt, dm_gnt, if_gnt};
  endfunction

  function automatic logic [2:0] rvs();
    return {ld_rvalid, dm_rvalid, if_rvalid};
  endfunction

  logic [2:0] starve_seq [10];
  logic [2:0] hold_seq [8];

  initial begin
    checks = 0;
    failures = 0;

    // Reset with requests pending: no grants, no writes, no rvalid.
    rst = 1'b0;
    drive_dm_if(1'b1, 1'b1, 1'b1);
    #2;
    check_output("reset_gnt", 32'(gnts()), 32'd0);
    check_output("reset_wen", 32'(sram_w_en), 32'd0);
    check_output("reset_rvalid", 32'(rvs()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    //                name          ir  ia       dr  dw    da       dd            lr  lw    la       ldd           gnt     wen   addr     rv      rdata
    vecs.push_back(mk("ld_wr_0010", 0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,        1, 4'hF, 16'h0010, 32'hDEADBEEF, 3'b100, 4'hF, 16'h0010, 3'b000, 32'h0));
    vecs.push_back(mk("if_rd_0010", 1, 16'h0010, 0, 4'h0, 16'h0000, 32'h0,        0, 4'h0, 16'h0000, 32'h0,        3'b001, 4'h0, 16'h0010, 3'b001, 32'hDEADBEEF));
    vecs.push_back(mk("ld_wr_9000", 0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,        1, 4'hF, 16'h9000, 32'hAABBCCDD, 3'b100, 4'hF, 16'h9000, 3'b000, 32'h0));
    vecs.push_back(mk("dm_wr_half", 0, 16'h0000, 1, 4'h3, 16'h9000, 32'h12345678, 0, 4'h0, 16'h0000, 32'h0,        3'b010, 4'h3, 16'h9000, 3'b000, 32'h0));
    vecs.push_back(mk("dm_rd_9000", 0, 16'h0000, 1, 4'h0, 16'h9000, 32'h0,        0, 4'h0, 16'h0000, 32'h0,        3'b010, 4'h0, 16'h9000, 3'b010, 32'hAABB5678));
    vecs.push_back(mk("ld_rd_0010", 0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,        1, 4'h0, 16'h0010, 32'h0,        3'b100, 4'h0, 16'h0010, 3'b100, 32'hDEADBEEF));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("all_req",  1, 16'h0010, 1, 4'h0, 16'h9000, 32'h0,        1, 4'hF, 16'h0020, 32'h11111111, 3'b100, 4'hF, 16'h0020, 3'b000, 32'h0));
    vecs.push_back(mk("dm_over_if", 1, 16'h0010, 1, 4'h0, 16'h9000, 32'h0,        0, 4'h0, 16'h0000, 32'h0,        3'b010, 4'h0, 16'h9000, 3'b010, 32'hAABB5678));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk("idle",     0, 16'h0040, 0, 4'hF, 16'h0050, 32'h0,        0, 4'hF, 16'h0060, 32'h0,        3'b000, 4'h0, 16'h0040, 3'b000, 32'h0));
    vecs.push_back(mk("dm_rd_0020", 0, 16'h0000, 1, 4'h0, 16'h0020, 32'h0,        0, 4'h0, 16'h0000, 32'h0,        3'b010, 4'h0, 16'h0020, 3'b010, 32'h11111111));

    foreach (vecs[i]) begin
      @(negedge clk);
      apply_stimulus(vecs[i]);
      #1;
      check_output({vecs[i].name, "_gnt"}, 32'(gnts()), 32'(vecs[i].exp_gnt));
      check_output({vecs[i].name, "_wen"}, 32'(sram_w_en), 32'(vecs[i].exp_wen));
      check_output({vecs[i].name, "_addr"}, 32'(sram_address), 32'(vecs[i].exp_addr));
      @(posedge clk);
      #1;
      check_output({vecs[i].name, "_rvalid"}, 32'(rvs()), 32'(vecs[i].exp_rv));
      if (vecs[i].exp_rv != 3'b000) begin
        if (vecs[i].exp_rv[0]) check_output({vecs[i].name, "_if_rdata"}, if_rdata, vecs[i].exp_rdata);
        if (vecs[i].exp_rv[1]) check_output({vecs[i].name, "_dm_rdata"}, dm_rdata, vecs[i].exp_rdata);
        if (vecs[i].exp_rv[2]) check_output({vecs[i].name, "_ld_rdata"}, ld_rdata, vecs[i].exp_rdata);
      end
    end

    // DM and IF contend for 10 cycles: IF forced through every fifth cycle.
    starve_seq = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001,
                   3'b010, 3'b010, 3'b010, 3'b010, 3'b001};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_dm_if(1'b1, 1'b1, 1'b0);
      #1;
      check_output($sformatf("starve_gnt_%0d", i), 32'(gnts()), 32'(starve_seq[i]));
    end

    // Two DM wins, three LD cycles (count frozen at 2), then DM, DM, IF.
    hold_seq = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b010, 3'b010, 3'b001};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_dm_if(1'b1, 1'b1, (i >= 2 && i <= 4));
      #1;
      check_output($sformatf("hold_gnt_%0d", i), 32'(gnts()), 32'(hold_seq[i]));
    end

    // Reset in the middle of a DM read return.
    @(negedge clk);
    drive_dm_if(1'b0, 1'b1, 1'b0);
    #1;
    check_output("rstmid_gnt", 32'(gnts()), 32'b010);
    @(posedge clk);
    #1;
    check_output("rstmid_rvalid_before", 32'(rvs()), 32'b010);
    @(negedge clk);
    rst = 1'b0;
    dm_w_en = 4'hF;
    #1;
    check_output("rstmid_rvalid_in_reset", 32'(rvs()), 32'b000);
    check_output("rstmid_gnt_in_reset", 32'(gnts()), 32'b000);
    check_output("rstmid_wen_in_reset", 32'(sram_w_en), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive_dm_if(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("rstmid_quiet_%0d", i), 32'(rvs()), 32'b000);
    end
    @(negedge clk);
    drive_dm_if(1'b0, 1'b1, 1'b0);
    #1;
    check_output("rstmid_regrant", 32'(gnts()), 32'b010);
    @(posedge clk);
    #1;
    check_output("rstmid_rvalid_after", 32'(rvs()), 32'b010);
    check_output("rstmid_rdata_after", dm_rdata, 32'hAABB5678);
    @(negedge clk);
    drive_dm_if(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port SRAM (4-bit byte write enable, 16-bit byte address, 32-bit data) between three requesters: instruction fetch (IF), data access (DM) and a program loader/debug port (LD).
- Sits between the Top core and a unified SRAM instance, so the core can run from one memory.
- Grants one requester per cycle and routes the read data back one cycle later.
- Includes a starvation guard so IF cannot be locked out by back-to-back DM traffic.

Parameters:
- ADDR_W, 16, SRAM byte-address width
- DATA_W, 32, SRAM data width
- MAX_WAIT, 4, consecutive cycles IF may be denied by DM before IF is forced ahead of DM (range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  IF access request
- if_addr  in  ADDR_W  IF address (read only)
- if_gnt  out  1  IF granted this cycle
- if_rvalid  out  1  IF read data valid
- if_rdata  out  DATA_W  IF read data
- dm_req  in  1  DM access request
- dm_w_en  in  4  DM byte write enables; 0 means read
- dm_addr  in  ADDR_W  DM address
- dm_wdata  in  DATA_W  DM write data
- dm_gnt  out  1  DM granted this cycle
- dm_rvalid  out  1  DM read data valid
- dm_rdata  out  DATA_W  DM read data
- ld_req  in  1  loader request
- ld_w_en  in  4  loader byte write enables; 0 means read
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader granted this cycle
- ld_rvalid  out  1  loader read data valid
- ld_rdata  out  DATA_W  loader read data
- sram_w_en  out  4  to SRAM w_en
- sram_address  out  ADDR_W  to SRAM address
- sram_write_data  out  DATA_W  to SRAM write_data
- sram_read_data  in  DATA_W  from SRAM read_data; valid the cycle after the address is presented

Behaviour:
- **Grant logic** is combinational from the current requests and the starvation state. At most one gnt is high per cycle.
- **Priority:**
  - LD is highest, always.
  - Otherwise DM before IF, unless starve_cnt == MAX_WAIT, in which case IF wins.
- **starve_cnt** is 4-bit and registered:
  - Increments when if_req=1 and DM is granted.
  - Clears when IF is granted or if_req=0.
  - Holds when LD is granted.
  - Saturates at MAX_WAIT.
- **SRAM drive:**
  - sram_address, sram_w_en and sram_write_data are muxed from the granted port.
  - sram_w_en is forced to 0 for IF.
  - With no grant, sram_w_en=0 and address/data hold the IF values (a harmless read).
- **Requester rules:**
  - A requester holds req and its payload stable until it sees gnt.
  - A request is consumed in the cycle gnt=1.
  - Back-to-back grants to the same port are allowed.
- **Read return:**
  - The registered signal rsel (2-bit, NONE/IF/DM/LD) captures the granted port when the granted access is a read (w_en==0).
  - rsel is NONE for writes or when there is no grant.
  - Next cycle, x_rvalid=1 only for the port in rsel.
  - All x_rdata outputs are driven by sram_read_data continuously; they are meaningful only while the matching rvalid is high.
- **Writes:** no rvalid. gnt is the completion.
- **Latency:** grant in 0 cycles when uncontested; read data 1 cycle after grant.
- **Reset (rst=0):**
  - Asynchronously clears rsel to NONE and starve_cnt to 0, so all rvalid go 0 immediately.
  - gnt outputs follow req combinationally, but are forced to 0 while rst=0.
  - sram_w_en is 0 during reset.
  - A read granted in the cycle reset asserts is dropped; no rvalid is produced after release.
- **Simultaneous events:**
  - All three requesting: LD granted; starve_cnt holds.
  - DM and IF requesting with starve_cnt==MAX_WAIT: IF granted, counter cleared, DM waits exactly one cycle.

Decomposition:
- Shared package holds:
  - rsel encoding constants: SEL_NONE=0, SEL_IF=1, SEL_DM=2, SEL_LD=3.
  - ADDR_W/DATA_W defaults matching the SRAM.
  - The 4-bit w_en "read" constant 4'b0000.
- One natural sub-module, arb_priority_sel: combinational priority plus starvation-override selector producing a one-hot grant. The top level holds starve_cnt, rsel and the datapath muxes.

Test Plan:
- **Single IF read:** reset, write mem[0x0010]=0xDEADBEEF via LD, then if_req with if_addr=0x0010.
  - if_gnt=1 in the same cycle.
  - if_rvalid=1 with if_rdata=0xDEADBEEF the next cycle.
  - dm_rvalid and ld_rvalid stay 0.
- **DM byte write:** dm_w_en=4'b0011, dm_addr=0x9000, dm_wdata=0x12345678, then read back via DM.
  - Low halfword is 0x5678 and the upper bytes are unchanged.
  - No rvalid on the write cycle.
- **LD priority:** LD, DM and IF all request for 3 cycles.
  - ld_gnt on all 3 cycles.
  - dm_gnt=if_gnt=0.
  - starve_cnt stays 0.
- **Starvation override (MAX_WAIT=4):** DM and IF request continuously for 10 cycles.
  - Grant sequence is DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
- **Reset mid-read:** grant a DM read, then drive rst=0 half a cycle later.
  - dm_rvalid=0 immediately.
  - After rst=1, no rvalid appears until a new grant.
- **Idle:** all req=0 for 5 cycles.
  - No gnt, no rvalid.
  - sram_w_en=0 every cycle.
